// File: rtl/mem_loader.sv
// Copies N_WORDS words from a program ROM into an asynchronous SRAM.
// Latency: 3+WE_CYCLES clocks per word, N_WORDS*(3+WE_CYCLES) clocks from the Start edge to Done.
// No backpressure: Start is ignored while Busy, and all SRAM strobes are registered.
module mem_loader #(
    parameter int unsigned N_WORDS   = 256,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [15:0] ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Data_oe,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Count
);

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, WRITE, HOLD, DONE} state_t;

    localparam logic [16:0] LAST_IDX  = 17'(N_WORDS - 1);
    localparam logic [3:0]  WCNT_LOAD = 4'(WE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [16:0] idx, idx_nxt, idx_p1;
    logic [3:0]  wcnt, wcnt_nxt;
    logic [15:0] cnt_nxt, rom_addr_nxt, dat_nxt, sram_word;
    logic [19:0] addr_nxt;
    logic        busy_nxt, done_nxt, sel_nxt, we_nxt;

    assign idx_p1    = idx + 17'd1;
    assign sram_word = BASE + idx[15:0];

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        wcnt_nxt     = wcnt;
        cnt_nxt      = Count;
        rom_addr_nxt = ROM_ADDR;
        addr_nxt     = ADDR;
        dat_nxt      = Data_to_SRAM;
        busy_nxt     = Busy;
        done_nxt     = Done;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_nxt    = FETCH;
                    idx_nxt      = 17'd0;
                    cnt_nxt      = 16'd0;
                    rom_addr_nxt = 16'd0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                end
            end
            FETCH: begin
                state_nxt = SETUP;
                addr_nxt  = {4'b0000, sram_word};
            end
            SETUP: begin
                // ROM word for this index is stable by the end of SETUP
                state_nxt = WRITE;
                dat_nxt   = ROM_DATA;
                wcnt_nxt  = WCNT_LOAD;
            end
            WRITE: begin
                if (wcnt == 4'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = Count + 16'd1;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            HOLD: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt    = FETCH;
                    idx_nxt      = idx_p1;
                    rom_addr_nxt = idx_p1[15:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Strobes decoded from the next state and registered, so they never glitch
        sel_nxt = (state_nxt == SETUP) || (state_nxt == WRITE) || (state_nxt == HOLD);
        we_nxt  = (state_nxt != WRITE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            idx          <= 17'd0;
            wcnt         <= 4'd0;
            Count        <= 16'd0;
            ROM_ADDR     <= 16'd0;
            ADDR         <= 20'd0;
            Data_to_SRAM <= 16'd0;
            Data_oe      <= 1'b0;
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            wcnt         <= wcnt_nxt;
            Count        <= cnt_nxt;
            ROM_ADDR     <= rom_addr_nxt;
            ADDR         <= addr_nxt;
            Data_to_SRAM <= dat_nxt;
            Data_oe      <= sel_nxt;
            CE           <= ~sel_nxt;
            UB           <= ~sel_nxt;
            LB           <= ~sel_nxt;
            OE           <= 1'b1;
            WE           <= we_nxt;
            Busy         <= busy_nxt;
            Done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench: three loaders (default, single-word, wrapping base) against a 1-clock ROM model.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic        start    [3];
    logic [15:0] rom_addr [3];
    logic [15:0] rom_data [3];
    logic [19:0] addr     [3];
    logic [15:0] dat      [3];
    logic        data_oe  [3];
    logic        ce [3], ub [3], lb [3], oe [3], we [3];
    logic        busy [3], done [3];
    logic [15:0] count    [3];

    int n_cmp = 0;
    int n_bad = 0;
    logic [37:0] exp_q [$];
    int we_run [3], n_writes [3];
    logic prev_we [3], after_hold [3];
    int ctl_viol = 0;
    int hi_viol  = 0;
    int wc [3] = '{2, 1, 2};

    always #5 clk = ~clk;

    mem_loader u0 (
        .Clk(clk), .Reset(rst[0]), .Start(start[0]), .ROM_ADDR(rom_addr[0]), .ROM_DATA(rom_data[0]),
        .ADDR(addr[0]), .Data_to_SRAM(dat[0]), .Data_oe(data_oe[0]), .CE(ce[0]), .UB(ub[0]),
        .LB(lb[0]), .OE(oe[0]), .WE(we[0]), .Busy(busy[0]), .Done(done[0]), .Count(count[0])
    );
    mem_loader #(.N_WORDS(1), .WE_CYCLES(1)) u1 (
        .Clk(clk), .Reset(rst[1]), .Start(start[1]), .ROM_ADDR(rom_addr[1]), .ROM_DATA(rom_data[1]),
        .ADDR(addr[1]), .Data_to_SRAM(dat[1]), .Data_oe(data_oe[1]), .CE(ce[1]), .UB(ub[1]),
        .LB(lb[1]), .OE(oe[1]), .WE(we[1]), .Busy(busy[1]), .Done(done[1]), .Count(count[1])
    );
    mem_loader #(.N_WORDS(4), .BASE(16'hFFFE)) u2 (
        .Clk(clk), .Reset(rst[2]), .Start(start[2]), .ROM_ADDR(rom_addr[2]), .ROM_DATA(rom_data[2]),
        .ADDR(addr[2]), .Data_to_SRAM(dat[2]), .Data_oe(data_oe[2]), .CE(ce[2]), .UB(ub[2]),
        .LB(lb[2]), .OE(oe[2]), .WE(we[2]), .Busy(busy[2]), .Done(done[2]), .Count(count[2])
    );

    // ROM with one clock of read latency
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) rom_data[k] <= rom_addr[k] ^ 16'hA5A5;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_load(input int k, input logic [15:0] base, input int n);
        logic [15:0] a, idx;
        for (int i = 0; i < n; i++) begin
            idx = 16'(i);
            a   = base + idx;
            exp_q.push_back({2'(k), 4'b0000, a, idx ^ 16'hA5A5});
        end
    endtask

    // Returns after the edge that samples Start, 1 time unit later
    task automatic start_edge(input int k, input bit hold);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 if (!hold) start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit, output int n);
        n = 0;
        while (!done[k] && n < limit) begin
            @(posedge clk); #1 n++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                prev_we[k] = 1'b1; we_run[k] = 0; after_hold[k] = 1'b0;
            end else begin
                if (!oe[k]) ctl_viol++;
                if (addr[k][19:16] != 4'h0) hi_viol++;
                if (!we[k] && (!data_oe[k] || ce[k])) ctl_viol++;
                if (!busy[k] && (data_oe[k] || !we[k])) ctl_viol++;
                if (after_hold[k] && (data_oe[k] || !we[k])) ctl_viol++;
                after_hold[k] = 1'b0;
                if (!we[k]) begin
                    we_run[k]++;
                end else if (!prev_we[k]) begin
                    check_val("we_width", 64'(we_run[k]), 64'(wc[k]));
                    if (exp_q.size() == 0) check_val("extra_write", 1, 0);
                    else check_val("write", {2'(k), addr[k], dat[k]}, exp_q.pop_front());
                    we_run[k] = 0; n_writes[k]++; after_hold[k] = 1'b1;
                end
                prev_we[k] = we[k];
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; n_writes[k] = 0; we_run[k] = 0;
            prev_we[k] = 1'b1; after_hold[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("rst_ctl", {we[k], ce[k], ub[k], lb[k], oe[k], data_oe[k], busy[k], done[k]}, 8'b11111000);
            check_val("rst_regs", {count[k], addr[k], rom_addr[k], dat[k]}, 68'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // single word, one-clock WE pulse
        push_load(1, 16'h0000, 1);
        start_edge(1, 0);
        wait_done(1, 100, n);
        check_val("u1_done_lat", n, 4);
        check_val("u1_addr", addr[1], 20'h00000);
        check_val("u1_count", count[1], 1);
        check_val("u1_writes", n_writes[1], 1);

        // base wraps past 0xFFFF
        push_load(2, 16'hFFFE, 4);
        start_edge(2, 0);
        wait_done(2, 200, n);
        check_val("u2_done_lat", n, 20);
        check_val("u2_count", count[2], 4);
        check_val("u2_end_addr", addr[2], 20'h00001);
        check_val("u2_q_empty", exp_q.size(), 0);

        // full default load
        push_load(0, 16'h0000, 256);
        start_edge(0, 0);
        wait_done(0, 3000, n);
        check_val("u0_done_lat", n, 1280);
        check_val("u0_count", count[0], 256);
        check_val("u0_idle_flags", {busy[0], done[0], we[0], data_oe[0], ce[0]}, 5'b01101);
        check_val("u0_q_empty", exp_q.size(), 0);

        // reset during the WRITE of word 5
        push_load(0, 16'h0000, 256);
        start_edge(0, 0);
        repeat (27) @(posedge clk);
        #1;
        check_val("pre_rst_we", we[0], 0);
        check_val("pre_rst_count", count[0], 5);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_write", {we[0], data_oe[0], busy[0], ce[0], count[0]}, {4'b1001, 16'd0});
        check_val("rst_words_done", exp_q.size(), 251);
        exp_q.delete();
        rst[0] = 1'b0;

        // reload with Start held high throughout, then immediate restart
        push_load(0, 16'h0000, 256);
        start_edge(0, 1);
        check_val("reload_rom_addr", rom_addr[0], 0);
        wait_done(0, 3000, n);
        check_val("held_done_lat", n, 1280);
        check_val("held_count", count[0], 256);
        push_load(0, 16'h0000, 256);
        @(posedge clk); #1;
        check_val("restart", {busy[0], done[0], count[0]}, {2'b10, 16'd0});
        start[0] = 1'b0;
        wait_done(0, 3000, n);
        check_val("restart_done_lat", n, 1280);
        check_val("restart_q_empty", exp_q.size(), 0);

        check_val("ctl_violations", ctl_viol, 0);
        check_val("addr_hi_violations", hi_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
